// File: rtl/present_decipher_seq_pkg.sv
// Shared types, S-box tables and PRESENT-16/20 round helpers for the round-serial decipher core.
package present_decipher_seq_pkg;

   localparam int BLOCK_W    = 16;
   localparam int KEY_W      = 20;
   localparam int RC_W       = 5;
   localparam int ROUNDS_DEF = 31;

   typedef logic [BLOCK_W-1:0] block_t;
   typedef logic [KEY_W-1:0]   key_t;
   typedef logic [RC_W-1:0]    rc_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_KEYEXP,
      ST_DECRYPT,
      ST_DONE
   } state_e;

   localparam logic [3:0] SBOX [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };
   localparam logic [3:0] INV_SBOX [16] = '{
      4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
      4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
   };

   function automatic logic [3:0] sbox(input logic [3:0] x);
      return SBOX[x];
   endfunction

   function automatic logic [3:0] inv_sbox(input logic [3:0] x);
      return INV_SBOX[x];
   endfunction

   // Bit i moves to (4*i) mod 15; bit 15 stays put.
   function automatic block_t p_layer(input block_t x);
      block_t y;
      y = '0;
      for (int i = 0; i < BLOCK_W - 1; i++) y[(4 * i) % 15] = x[i];
      y[BLOCK_W-1] = x[BLOCK_W-1];
      return y;
   endfunction

   function automatic block_t inv_p_layer(input block_t x);
      block_t y;
      y = '0;
      for (int i = 0; i < BLOCK_W - 1; i++) y[i] = x[(4 * i) % 15];
      y[BLOCK_W-1] = x[BLOCK_W-1];
      return y;
   endfunction

   // Forward schedule step: rotate left 13, S-box top nibble, XOR round counter into low bits.
   function automatic key_t key_update(input key_t k, input rc_t rc);
      key_t r;
      r        = {k[6:0], k[19:7]};
      r[19:16] = sbox(r[19:16]);
      r[4:0]   = r[4:0] ^ rc;
      return r;
   endfunction

   function automatic key_t inv_key_update(input key_t k, input rc_t rc);
      key_t t;
      t        = k;
      t[4:0]   = t[4:0] ^ rc;
      t[19:16] = inv_sbox(t[19:16]);
      return {t[12:0], t[19:13]};
   endfunction

endpackage

// File: rtl/present_decipher_seq_if.sv
// Ciphertext-in / plaintext-out handshake bundle of the decipher core.
interface present_decipher_seq_if;
   import present_decipher_seq_pkg::*;

   logic   in_valid;
   logic   in_ready;
   block_t ciphertext;
   key_t   master_key;
   logic   out_valid;
   logic   out_ready;
   block_t plaintext;
   logic   busy;

   modport slave (
      input  in_valid, ciphertext, master_key, out_ready,
      output in_ready, out_valid, plaintext, busy
   );

   modport master (
      output in_valid, ciphertext, master_key, out_ready,
      input  in_ready, out_valid, plaintext, busy
   );

endinterface

// File: rtl/present_decipher_seq_round.sv
// One inverse PRESENT round: inverse permutation, inverse S-box on every nibble, round-key XOR.
module present_dec_round
   import present_decipher_seq_pkg::*;
(
   input  block_t state_i,
   input  block_t round_key_i,
   output block_t state_o
);

   block_t perm;
   block_t subst;

   always_comb begin
      perm  = inv_p_layer(state_i);
      subst = '0;
      for (int n = 0; n < BLOCK_W / 4; n++) subst[4*n +: 4] = inv_sbox(perm[4*n +: 4]);
      state_o = subst ^ round_key_i;
   end

endmodule

// File: rtl/present_decipher_seq.sv
// Round-serial PRESENT-16/20 decryption: forward key expansion (or cached final key),
// then one inverse round per clock with the key stepped backwards alongside.
module present_decipher_seq
   import present_decipher_seq_pkg::*;
#(
   parameter int ROUNDS    = ROUNDS_DEF,
   parameter bit KEY_CACHE = 1'b1
) (
   input logic                    clk,
   input logic                    rst_n,
   present_decipher_seq_if.slave  bus
);

   localparam int CNT_W = $clog2(ROUNDS + 2);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ROUNDS);
   localparam logic [CNT_W-1:0] CNT_WHITEN = CNT_W'(ROUNDS + 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   block_t           blk_q, blk_d;
   key_t             key_q, key_d;
   logic             cache_valid_q, cache_valid_d;
   key_t             cache_key_q, cache_key_d;
   key_t             cache_fin_q, cache_fin_d;

   rc_t    rc;
   key_t   key_fwd;
   key_t   key_bwd;
   block_t round_out;
   logic   cache_hit;

   assign rc        = RC_W'(cnt_q);
   assign key_fwd   = key_update(key_q, rc);
   assign key_bwd   = inv_key_update(key_q, rc);
   assign cache_hit = KEY_CACHE && cache_valid_q && (bus.master_key == cache_key_q);

   present_dec_round u_round (
      .state_i     (blk_q),
      .round_key_i (key_bwd[KEY_W-1 -: BLOCK_W]),
      .state_o     (round_out)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      blk_d         = blk_q;
      key_d         = key_q;
      cache_valid_d = cache_valid_q;
      cache_key_d   = cache_key_q;
      cache_fin_d   = cache_fin_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               blk_d = bus.ciphertext;
               if (cache_hit) begin
                  key_d   = cache_fin_q;
                  cnt_d   = CNT_WHITEN;
                  state_d = ST_DECRYPT;
               end else begin
                  key_d         = bus.master_key;
                  cache_valid_d = 1'b0;
                  cache_key_d   = bus.master_key;
                  cnt_d         = CNT_ONE;
                  state_d       = ST_KEYEXP;
               end
            end
         end
         ST_KEYEXP: begin
            key_d = key_fwd;
            if (cnt_q == CNT_LAST) begin
               cnt_d         = CNT_WHITEN;
               cache_valid_d = 1'b1;
               cache_fin_d   = key_fwd;
               state_d       = ST_DECRYPT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DECRYPT: begin
            // The first decrypt cycle only strips the final whitening key.
            if (cnt_q == CNT_WHITEN) begin
               blk_d = blk_q ^ key_q[KEY_W-1 -: BLOCK_W];
            end else begin
               key_d = key_bwd;
               blk_d = round_out;
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_ONE) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         blk_q         <= '0;
         cache_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         blk_q         <= blk_d;
         cache_valid_q <= cache_valid_d;
      end
   end

   // Key material is qualified by state/cache_valid, so it needs no reset.
   always_ff @(posedge clk) begin
      key_q       <= key_d;
      cache_key_q <= cache_key_d;
      cache_fin_q <= cache_fin_d;
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q == ST_KEYEXP) || (state_q == ST_DECRYPT);
   assign bus.plaintext = blk_q;

endmodule

// File: tb/tb_present_decipher_seq.sv
// Self-checking bench: an integer-arithmetic PRESENT-16/20 encipher produces ciphertexts whose
// decryption must return the original block with the expected cache-dependent latency.
module tb_present_decipher_seq;

   localparam int R        = 31;
   localparam int LAT_MISS = 2 * R + 2;
   localparam int LAT_HIT  = R + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   present_decipher_seq_if bus();

   present_decipher_seq #(.ROUNDS(R), .KEY_CACHE(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int hs_cnt = 0;

   // Bench-side view of the key cache: last fully expanded key, if still valid.
   bit          cv = 1'b0;
   logic [19:0] ck = '0;

   typedef struct {
      logic [15:0] pt;
      logic [19:0] key;
      int          lat;
   } vec_t;
   vec_t tbl[6];

   int SB[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

   always @(negedge clk) if (rst_n && bus.out_valid && bus.out_ready) hs_cnt++;

   function automatic logic [15:0] enc(input logic [15:0] pt, input logic [19:0] key);
      int          k;
      logic [15:0] s;
      logic [15:0] t;
      k = int'(key);
      s = pt;
      for (int r = 1; r <= R; r++) begin
         s = s ^ 16'(k >> 4);
         for (int n = 0; n < 4; n++) s[4*n +: 4] = 4'(SB[s[4*n +: 4]]);
         t = '0;
         for (int i = 0; i < 16; i++) t[(i == 15) ? 15 : (4 * i) % 15] = s[i];
         s = t;
         k = ((k << 13) | (k >> 7)) & 32'hFFFFF;
         k = (k & 32'hFFFF) | (SB[(k >> 16) & 15] << 16);
         k = k ^ (r & 31);
      end
      return s ^ 16'(k >> 4);
   endfunction

   function automatic int exp_lat(input logic [19:0] key);
      return (cv && key == ck) ? LAT_HIT : LAT_MISS;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input logic [15:0] pt, input logic [19:0] key, input int lat_exp,
                          input int hold, input string nm);
      logic [15:0] ct;
      int lat, busy_low, w, held_bad;
      ct = enc(pt, key);
      w  = 0;
      while (!bus.in_ready && w < 200) begin tick(); w++; end
      chk({nm, " in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid   = 1'b1;
      bus.ciphertext = ct;
      bus.master_key = key;
      bus.out_ready  = (hold == 0);
      tick();
      bus.in_valid   = 1'b0;
      bus.ciphertext = 16'($urandom);
      bus.master_key = 20'($urandom);
      lat      = 1;
      busy_low = 0;
      while (!bus.out_valid && lat < 300) begin
         if (!bus.busy) busy_low++;
         tick();
         lat++;
      end
      chk({nm, " latency"}, 32'(lat), 32'(lat_exp));
      chk({nm, " busy"}, 32'(busy_low), 32'd0);
      chk({nm, " plaintext"}, 32'(bus.plaintext), 32'(pt));
      held_bad = 0;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (!bus.out_valid || bus.plaintext !== pt || bus.in_ready) held_bad++;
      end
      if (hold > 0) chk({nm, " hold"}, 32'(held_bad), 32'd0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({nm, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
      cv = 1'b1;
      ck = key;
   endtask

   initial begin
      logic [15:0] pt;
      logic [19:0] key;
      int hs0, n;

      tbl[0] = '{16'h0000, 20'h00000, LAT_MISS};
      tbl[1] = '{16'hdead, 20'hbeef5, LAT_MISS};
      tbl[2] = '{16'h1234, 20'hbeef5, LAT_HIT};
      tbl[3] = '{16'ha5a5, 20'h12345, LAT_MISS};
      tbl[4] = '{16'hffff, 20'h12345, LAT_HIT};
      tbl[5] = '{16'h0001, 20'hbeef5, LAT_MISS};

      bus.in_valid   = 1'b0;
      bus.ciphertext = '0;
      bus.master_key = '0;
      bus.out_ready  = 1'b0;
      repeat (3) tick();
      chk("rst in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst plaintext", 32'(bus.plaintext), 32'h0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++)
         run_job(tbl[i].pt, tbl[i].key, tbl[i].lat, 0, $sformatf("vec%0d", i));

      // Sink stalls for 20 cycles: output and backpressure must hold.
      run_job(16'h9e37, 20'hfffff, exp_lat(20'hfffff), 20, "stall");

      // Reset in the middle of decryption.
      hs0 = hs_cnt;
      bus.in_valid   = 1'b1;
      bus.ciphertext = enc(16'h4b1d, 20'h00000);
      bus.master_key = 20'h00000;
      tick();
      bus.in_valid = 1'b0;
      repeat (R + 5) tick();
      chk("midrst busy before", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst busy", 32'(bus.busy), 32'd0);
      chk("midrst plaintext", 32'(bus.plaintext), 32'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      cv = 1'b0;
      tick();
      chk("midrst no handshake", 32'(hs_cnt - hs0), 32'd0);
      run_job(16'h7777, 20'h00000, LAT_MISS, 0, "after rst");

      // New requests offered while busy must be ignored.
      hs0 = hs_cnt;
      pt  = 16'hc0de;
      key = 20'h31415;
      n   = exp_lat(key);
      bus.in_valid   = 1'b1;
      bus.ciphertext = enc(pt, key);
      bus.master_key = key;
      tick();
      n = 1;
      while (!bus.out_valid && n < 300) begin
         bus.in_valid   = 1'b1;
         bus.ciphertext = 16'($urandom);
         bus.master_key = 20'($urandom);
         tick();
         n++;
      end
      bus.in_valid = 1'b0;
      chk("busy-spam plaintext", 32'(bus.plaintext), 32'(pt));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      repeat (2 * R + 6) tick();
      chk("busy-spam handshakes", 32'(hs_cnt - hs0), 32'd1);
      chk("busy-spam idle", 32'(bus.out_valid), 32'd0);
      cv = 1'b1;
      ck = key;

      // Randomized round trips with random sink stalls and frequent key reuse.
      hs0 = hs_cnt;
      for (int j = 0; j < 1000; j++) begin
         pt  = 16'($urandom);
         key = ($urandom_range(0, 3) == 0) ? ck : 20'($urandom);
         run_job(pt, key, exp_lat(key), $urandom_range(0, 3), $sformatf("rnd%0d", j));
      end
      chk("random handshakes", 32'(hs_cnt - hs0), 32'd1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
